// File: rtl/ws2812b_pkg.sv
// Shared definitions for the WS2812B pixel sequencer: host register map,
// status bit positions and the auto-read FSM encoding.
package ws2812b_pkg;

  localparam logic [3:0] ADDR_R      = 4'h0;
  localparam logic [3:0] ADDR_G      = 4'h1;
  localparam logic [3:0] ADDR_B      = 4'h2;
  localparam logic [3:0] ADDR_STATUS = 4'h3;
  localparam logic [3:0] ADDR_COUNT  = 4'h4;

  localparam int STAT_NONEMPTY  = 0;
  localparam int STAT_COUNT_LSB = 1;
  localparam int STAT_COUNT_MSB = 2;
  localparam int STAT_OVERFLOW  = 3;
  localparam int STAT_BUSY      = 4;
  localparam int STAT_ENABLE    = 5;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_RD_R     = 3'd1,
    ST_RD_G     = 3'd2,
    ST_RD_B     = 3'd3,
    ST_WAIT_CLR = 3'd4
  } state_e;

endpackage

// File: rtl/ws2812b_pixel_fifo.sv
// Small 24-bit pixel FIFO. A push into a full FIFO is accepted only when a
// pop happens in the same cycle; a pop on an empty FIFO is ignored.
module ws2812b_pixel_fifo #(
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic [23:0]              wdata,
  output logic [23:0]              rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [23:0]   mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q;
  logic [AW-1:0] rd_ptr_q;
  logic [CW-1:0] count_q;
  logic          pop_ok;
  logic          push_ok;

  assign empty   = (count_q == '0);
  assign full    = (count_q == CW'(DEPTH));
  assign pop_ok  = pop && !empty;
  assign push_ok = push && (!full || pop_ok);
  assign rdata   = mem_q[rd_ptr_q];
  assign count   = count_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_q + CW'(push_ok) - CW'(pop_ok);
    end
  end

  // Storage needs no reset: entries are only visible once counted.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/ws2812b_rgb_sequencer.sv
// Auto-reads captured R/G/B bytes from the demux register file, buffers
// whole pixels in a FIFO and exposes them through a byte register map.
module ws2812b_rgb_sequencer
  import ws2812b_pkg::*;
#(
  parameter int FIFO_DEPTH = 2,
  parameter int CNT_W      = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic       rgb_ready,
  input  logic       idle,
  input  logic [7:0] rgb_byte,
  output logic       dmx_read_en,
  output logic [3:0] dmx_read_address,
  input  logic       host_read_en,
  input  logic [3:0] host_address,
  output logic [7:0] host_data,
  output logic       irq
);

  localparam int FCW = $clog2(FIFO_DEPTH) + 1;

  state_e           state_q, state_d;
  logic [7:0]       r_q, g_q;
  logic [CNT_W-1:0] pix_cnt_q, pix_cnt_d;
  logic             ovf_q, ovf_d;

  logic             push_req;
  logic             pop_req;
  logic             ovf_set;
  logic [23:0]      fifo_rdata;
  logic [23:0]      head;
  logic             fifo_full;
  logic             fifo_empty;
  logic [FCW-1:0]   fifo_count;
  logic [1:0]       count_sat;
  logic [7:0]       status;
  logic [7:0]       cnt_byte;

  // An idle gap mid-read abandons the partial pixel before anything else.
  always_comb begin
    state_d = state_q;
    if ((state_q == ST_RD_R || state_q == ST_RD_G || state_q == ST_RD_B) && idle) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE:     if (rgb_ready && enable && !idle) state_d = ST_RD_R;
        ST_RD_R:     state_d = ST_RD_G;
        ST_RD_G:     state_d = ST_RD_B;
        ST_RD_B:     state_d = ST_WAIT_CLR;
        ST_WAIT_CLR: if (!rgb_ready || idle) state_d = ST_IDLE;
        default:     state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    dmx_read_en      = 1'b0;
    dmx_read_address = 4'h0;
    case (state_q)
      ST_RD_R: begin dmx_read_en = 1'b1; dmx_read_address = ADDR_R; end
      ST_RD_G: begin dmx_read_en = 1'b1; dmx_read_address = ADDR_G; end
      ST_RD_B: begin dmx_read_en = 1'b1; dmx_read_address = ADDR_B; end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_q <= 8'h00;
      g_q <= 8'h00;
    end else begin
      if (state_q == ST_RD_R) r_q <= rgb_byte;
      if (state_q == ST_RD_G) g_q <= rgb_byte;
    end
  end

  assign push_req = (state_q == ST_RD_B) && !idle;
  assign pop_req  = host_read_en && (host_address == ADDR_B);
  assign ovf_set  = push_req && fifo_full && !pop_req;

  always_comb begin
    pix_cnt_d = pix_cnt_q;
    if (idle)                              pix_cnt_d = '0;
    else if (push_req && pix_cnt_q != '1)  pix_cnt_d = pix_cnt_q + CNT_W'(1);

    ovf_d = ovf_q;
    if (ovf_set)                                             ovf_d = 1'b1;
    else if (host_read_en && host_address == ADDR_STATUS)    ovf_d = 1'b0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pix_cnt_q <= '0;
      ovf_q     <= 1'b0;
    end else begin
      pix_cnt_q <= pix_cnt_d;
      ovf_q     <= ovf_d;
    end
  end

  ws2812b_pixel_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push_req),
    .pop   (pop_req),
    .wdata ({r_q, g_q, rgb_byte}),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  if (CNT_W >= 8) begin : g_cnt_wide
    assign cnt_byte = pix_cnt_q[7:0];
  end else begin : g_cnt_narrow
    assign cnt_byte = {{(8-CNT_W){1'b0}}, pix_cnt_q};
  end

  assign head      = fifo_empty ? 24'h000000 : fifo_rdata;
  assign count_sat = (fifo_count > FCW'(3)) ? 2'd3 : fifo_count[1:0];
  assign irq       = !fifo_empty;

  always_comb begin
    status = 8'h00;
    status[STAT_NONEMPTY]                  = !fifo_empty;
    status[STAT_COUNT_MSB:STAT_COUNT_LSB]  = count_sat;
    status[STAT_OVERFLOW]                  = ovf_q;
    status[STAT_BUSY]                      = (state_q != ST_IDLE);
    status[STAT_ENABLE]                    = enable;
  end

  always_comb begin
    host_data = 8'h00;
    case (host_address)
      ADDR_R:      host_data = head[23:16];
      ADDR_G:      host_data = head[15:8];
      ADDR_B:      host_data = head[7:0];
      ADDR_STATUS: host_data = status;
      ADDR_COUNT:  host_data = cnt_byte;
      default:     host_data = 8'h00;
    endcase
  end

endmodule

// File: tb/tb_ws2812b_rgb_sequencer.sv
// Bench for the pixel sequencer: a queue-based pixel model checked every
// cycle, directed scenarios with literal expectations, then random traffic.
module tb_ws2812b_rgb_sequencer;

  localparam int DEPTH = 2;
  localparam int CNT_W = 8;
  localparam int MAXC  = (1 << CNT_W) - 1;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       enable = 1'b0;
  logic       rgb_ready = 1'b0;
  logic       idle = 1'b0;
  logic [7:0] rgb_byte;
  logic       dmx_read_en;
  logic [3:0] dmx_read_address;
  logic       host_read_en = 1'b0;
  logic [3:0] host_address = 4'h0;
  logic [7:0] host_data;
  logic       irq;

  logic [7:0] regfile [3];

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  // The demux register file as seen on its read port.
  always_comb rgb_byte = (dmx_read_address < 4'd3) ? regfile[dmx_read_address[1:0]] : 8'h00;

  ws2812b_rgb_sequencer #(
    .FIFO_DEPTH (DEPTH),
    .CNT_W      (CNT_W)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .enable           (enable),
    .rgb_ready        (rgb_ready),
    .idle             (idle),
    .rgb_byte         (rgb_byte),
    .dmx_read_en      (dmx_read_en),
    .dmx_read_address (dmx_read_address),
    .host_read_en     (host_read_en),
    .host_address     (host_address),
    .host_data        (host_data),
    .irq              (irq)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Model: phase counts read cycles (0 none, 1..3 reading R/G/B, 4 waiting
  // for the demux to drop its flag); pixels live in a plain queue.
  int          m_phase = 0;
  logic [7:0]  m_r = 8'h00;
  logic [7:0]  m_g = 8'h00;
  logic [23:0] m_q[$];
  bit          m_ovf = 1'b0;
  int          m_cnt = 0;

  always @(posedge clk or posedge reset) begin
    bit pop, done, ovf_set;
    if (reset) begin
      m_phase = 0;
      m_q.delete();
      m_ovf = 1'b0;
      m_cnt = 0;
    end else begin
      pop  = host_read_en && host_address == 4'h2 && m_q.size() > 0;
      done = (m_phase == 3) && !idle;
      ovf_set = 1'b0;
      if (pop) void'(m_q.pop_front());
      if (done) begin
        if (m_q.size() < DEPTH) m_q.push_back({m_r, m_g, regfile[2]});
        else ovf_set = 1'b1;
      end
      if (ovf_set) m_ovf = 1'b1;
      else if (host_read_en && host_address == 4'h3) m_ovf = 1'b0;
      if (idle) m_cnt = 0;
      else if (done && m_cnt < MAXC) m_cnt = m_cnt + 1;
      if (m_phase >= 1 && m_phase <= 3 && idle) m_phase = 0;
      else begin
        case (m_phase)
          0: if (rgb_ready && enable && !idle) m_phase = 1;
          1: begin m_r = regfile[0]; m_phase = 2; end
          2: begin m_g = regfile[1]; m_phase = 3; end
          3: m_phase = 4;
          default: if (!rgb_ready || idle) m_phase = 0;
        endcase
      end
    end
  end

  always @(negedge clk) begin
    logic        e_en;
    logic [3:0]  e_addr;
    logic [23:0] head;
    logic [7:0]  e_hd;
    int          sz;
    sz     = m_q.size();
    e_en   = (m_phase >= 1 && m_phase <= 3);
    e_addr = e_en ? 4'(m_phase - 1) : 4'h0;
    head   = (sz > 0) ? m_q[0] : 24'h0;
    case (host_address)
      4'h0: e_hd = head[23:16];
      4'h1: e_hd = head[15:8];
      4'h2: e_hd = head[7:0];
      4'h3: e_hd = {2'b00, enable, (m_phase != 0), m_ovf, ((sz > 3) ? 2'd3 : 2'(sz)), (sz > 0)};
      4'h4: e_hd = 8'(m_cnt);
      default: e_hd = 8'h00;
    endcase
    chk("dmx_read_en", dmx_read_en, e_en);
    chk("dmx_read_address", dmx_read_address, e_addr);
    chk("irq", irq, (sz > 0));
    chk("host_data", host_data, e_hd);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rd_lit(input string name, input logic [3:0] addr, input logic [7:0] exp);
    host_address = addr;
    #1;
    chk(name, host_data, exp);
  endtask

  task automatic host_rd(input logic [3:0] addr);
    host_address = addr;
    host_read_en = 1'b1;
    tick();
    host_read_en = 1'b0;
  endtask

  task automatic cap(input logic [7:0] r, input logic [7:0] g, input logic [7:0] b, input bit pop_in_rdb);
    regfile[0] = r;
    regfile[1] = g;
    regfile[2] = b;
    rgb_ready = 1'b1;
    tick(); tick(); tick();
    if (pop_in_rdb) begin
      host_address = 4'h2;
      host_read_en = 1'b1;
    end
    tick();
    host_read_en = 1'b0;
    rgb_ready = 1'b0;
    tick();
  endtask

  initial begin
    int n;
    regfile[0] = 8'h00; regfile[1] = 8'h00; regfile[2] = 8'h00;
    reset = 1'b1;

    @(negedge clk);
    chk("rst_strobe", dmx_read_en, 1'b0);
    chk("rst_addr", dmx_read_address, 4'h0);
    chk("rst_irq", irq, 1'b0);
    chk("rst_host_data", host_data, 8'h00);
    tick();
    reset = 1'b0;
    enable = 1'b1;
    tick();

    // Basic capture and latency.
    regfile[0] = 8'h12; regfile[1] = 8'h34; regfile[2] = 8'h56;
    rgb_ready = 1'b1;
    tick();
    @(negedge clk);
    chk("cap_strobe_r", {dmx_read_en, dmx_read_address}, 5'h10);
    tick();
    @(negedge clk);
    chk("cap_strobe_g", {dmx_read_en, dmx_read_address}, 5'h11);
    tick();
    @(negedge clk);
    chk("cap_strobe_b", {dmx_read_en, dmx_read_address}, 5'h12);
    chk("cap_irq_early", irq, 1'b0);
    tick();
    rgb_ready = 1'b0;
    @(negedge clk);
    chk("cap_irq_up", irq, 1'b1);
    rd_lit("cap_r", 4'h0, 8'h12);
    rd_lit("cap_g", 4'h1, 8'h34);
    rd_lit("cap_b", 4'h2, 8'h56);
    host_rd(4'h2);
    @(negedge clk);
    chk("cap_irq_down", irq, 1'b0);
    tick();

    // Overflow: three pixels into a two-deep FIFO.
    idle = 1'b1; tick(); idle = 1'b0;
    cap(8'hA1, 8'hB2, 8'hC3, 1'b0);
    cap(8'hD4, 8'hE5, 8'hF6, 1'b0);
    cap(8'h07, 8'h18, 8'h29, 1'b0);
    rd_lit("ovf_status", 4'h3, 8'h2D);
    rd_lit("ovf_pixcnt", 4'h4, 8'h03);
    host_rd(4'h3);
    rd_lit("ovf_cleared", 4'h3, 8'h25);
    rd_lit("ovf_head", 4'h0, 8'hA1);

    // Push and pop together on a full FIFO.
    cap(8'h33, 8'h44, 8'h55, 1'b1);
    rd_lit("pp_status", 4'h3, 8'h25);
    rd_lit("pp_head", 4'h0, 8'hD4);
    host_rd(4'h2);
    rd_lit("pp_tail", 4'h0, 8'h33);
    rd_lit("pp_tail_b", 4'h2, 8'h55);
    host_rd(4'h2);

    // Abort on idle during RD_G.
    rgb_ready = 1'b1;
    tick(); tick();
    idle = 1'b1;
    tick();
    idle = 1'b0;
    rgb_ready = 1'b0;
    rd_lit("abort_status", 4'h3, 8'h20);
    rd_lit("abort_pixcnt", 4'h4, 8'h00);
    chk("abort_irq", irq, 1'b0);
    tick();

    // Held ready: a single capture, then parked until the flag drops.
    regfile[0] = 8'h5A; regfile[1] = 8'h6B; regfile[2] = 8'h7C;
    rgb_ready = 1'b1;
    n = 0;
    repeat (14) begin
      tick(); #1;
      if (dmx_read_en) n++;
    end
    chk("held_strobes", n, 3);
    rd_lit("held_busy", 4'h3, 8'h33);
    rgb_ready = 1'b0;
    tick();
    rd_lit("held_released", 4'h3, 8'h23);
    rd_lit("held_pixel", 4'h1, 8'h6B);
    host_rd(4'h2);

    // Asynchronous reset in the middle of a read.
    cap(8'h11, 8'h22, 8'h33, 1'b0);
    rgb_ready = 1'b1;
    tick(); tick();
    #2 reset = 1'b1;
    #1;
    chk("arst_strobe", dmx_read_en, 1'b0);
    chk("arst_addr", dmx_read_address, 4'h0);
    chk("arst_irq", irq, 1'b0);
    rd_lit("arst_head", 4'h0, 8'h00);
    rgb_ready = 1'b0;
    #2 reset = 1'b0;
    n = 0;
    repeat (6) begin
      tick(); #1;
      if (dmx_read_en) n++;
    end
    chk("arst_no_strobe", n, 0);

    // Pixel counter saturation.
    idle = 1'b1; tick(); idle = 1'b0;
    repeat (MAXC + 5) cap(8'($urandom), 8'($urandom), 8'($urandom), 1'b0);
    rd_lit("sat_pixcnt", 4'h4, 8'hFF);
    idle = 1'b1; tick(); idle = 1'b0;
    rd_lit("sat_cleared", 4'h4, 8'h00);
    host_rd(4'h3);
    host_rd(4'h2);
    host_rd(4'h2);

    // Random traffic against the model.
    repeat (3000) begin
      tick();
      enable       = ($urandom_range(0, 9) != 0);
      rgb_ready    = ($urandom_range(0, 2) != 0);
      idle         = ($urandom_range(0, 19) == 0);
      host_read_en = ($urandom_range(0, 3) == 0);
      host_address = 4'($urandom_range(0, 6));
      regfile[0]   = 8'($urandom);
      regfile[1]   = 8'($urandom);
      regfile[2]   = 8'($urandom);
    end
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
